selector_step_ctrl: RTL and testbench
=====================================

# selector_step_ctrl

Front-end controller for the PWM duty selector counter. Turns two raw, bouncing, active-low push-buttons (up/down) into clean single-cycle step commands, with hold-to-auto-repeat. Its outputs drive the counter's `ena`, `sum` and `rest` inputs directly. It arbitrates between the two buttons so the counter never receives conflicting or glitched commands.

## Interface
Parameters:
- `DB_CYCLES`, default 50000: clocks a synchronized button level must stay stable before it is accepted (≥2).
- `REPEAT_DELAY`, default 25000000: clocks from the first step until auto-repeat starts (≥2).
- `REPEAT_PERIOD`, default 5000000: clocks between auto-repeat steps (≥2).
- `TMR_W`, default 25: timer width; must hold `max(DB_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)`.

Ports:
- `clk` in 1: single clock; all logic rising-edge.
- `rst` in 1: asynchronous, active-high reset.
- `btn_up_n` in 1: raw up button, active-low, asynchronous to `clk`.
- `btn_dn_n` in 1: raw down button, active-low, asynchronous to `clk`.
- `en` in 1: when low, no steps are issued. Timers and state still track the buttons.
- `step_ena` out 1: one-cycle step strobe, to counter `ena`.
- `step_sum` out 1: active-low increment command, to counter `sum`.
- `step_rest` out 1: active-low decrement command, to counter `rest`.
- `repeating` out 1: high while in auto-repeat.

## Operation
- Each button passes through a 2-flop synchronizer (reset value 1 = released), then a debouncer. The debounced level `up_db`/`dn_db` (active-high pressed, reset 0) changes only after the synchronized level has differed from it for `DB_CYCLES` consecutive clocks. Any bounce restarts the count.
- FSM states: IDLE, FIRST, HOLD, REPEAT, LOCKOUT. Reset state is IDLE.
  - IDLE: if exactly one of `up_db`/`dn_db` is high, latch the direction and go to FIRST. If both are high, go to LOCKOUT.
  - FIRST (one cycle): issue a step, load the timer with `REPEAT_DELAY-1`, go to HOLD.
  - HOLD: the timer counts down. When the latched button releases, go to IDLE. When the opposite button is also pressed, go to LOCKOUT. When the timer reaches 0, issue a step, load `REPEAT_PERIOD-1` and go to REPEAT.
  - REPEAT: same release and conflict exits as HOLD. When the timer reaches 0, issue a step and reload `REPEAT_PERIOD-1`.
  - LOCKOUT: no steps are issued. Go to IDLE only when both `up_db` and `dn_db` are 0.
- Issuing a step means, for exactly one cycle:
  - `step_ena`=1.
  - Up: `step_sum`=0, `step_rest`=1.
  - Down: `step_sum`=1, `step_rest`=0.
  - The step is suppressed (all outputs stay idle) if `en`=0 in that cycle. The FSM advances regardless.
- Idle outputs: `step_ena`=0, `step_sum`=1, `step_rest`=1.
- `sum`/`rest` are never both 0 in the same cycle.
- `repeating`=1 exactly while the state is REPEAT.

## Timing
- All outputs are registered.
- Reset values: `step_ena`=0, `step_sum`=1, `step_rest`=1, `repeating`=0.
- Press latency: raw low first sampled at edge k → `up_db` high after edge k+1+DB_CYCLES → FIRST state at k+2+DB_CYCLES → `step_ena` high for the cycle after edge k+3+DB_CYCLES. Without bounce this is DB_CYCLES+3 clocks.
- Second step: exactly `REPEAT_DELAY` clocks after the first step. Subsequent steps: every `REPEAT_PERIOD` clocks.
- Release is seen `DB_CYCLES`+2 clocks after the raw rise. A repeat step that falls due within that window is still issued.
- Simultaneous debounced presses in the same cycle go to LOCKOUT with no step.
- `rst` mid-repeat: outputs return to idle values immediately (asynchronously). The FSM goes to IDLE and synchronizers go to released. A button still held after reset is treated as a fresh press and produces a new FIRST step after the debounce delay.
- Timer arithmetic: unsigned, `TMR_W` bits. The timer never wraps; it is always reloaded from 0 or on a state change.

## Structure
- Package `selector_ctrl_pkg`:
  - State enum: IDLE, FIRST, HOLD, REPEAT, LOCKOUT.
  - Direction type: UP, DN.
  - Idle-output constants.
- Sub-module `btn_debounce`: parameters `DB_CYCLES`, `TMR_W`; ports `clk`, `rst`, `btn_n`, `pressed`. Contains the synchronizer and debounce counter, and is instantiated twice.
- The top level holds the FSM, the shared repeat timer and the output registers.

## Test plan
All scenarios use DB_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8.
- Clean `btn_up_n` low for 10 clocks → exactly one `step_ena` pulse, with `step_sum`=0 and `step_rest`=1, 7 clocks after the press. `repeating` stays 0.
- `btn_dn_n` with 3 bounces of 2 clocks each before settling low → a single down step, 7 clocks after the final settle. No step is produced during the bounces.
- `btn_up_n` held for 60 clocks → steps at t0, t0+20, t0+28, t0+36, …. `repeating`=1 from t0+20, and no step after the debounced release.
- Up held, then `btn_dn_n` pressed → no further steps. Releasing only up gives nothing; releasing both returns the FSM to IDLE. A new up press then steps normally.
- `en`=0 during a held press → no `step_ena`, but timers run. Raising `en` mid-repeat makes steps resume on the existing period grid.
- `rst` pulsed mid-repeat with up still held → outputs idle at once. A new first step follows 7 clocks after `rst` deasserts, then a repeat at +20.

Source files
------------

// File: rtl/selector_ctrl_pkg.sv
// Shared types and constants for the duty-selector step controller.
// Holds the FSM state encoding, the step direction and the counter command helper.
package selector_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FIRST   = 3'd1,
        ST_HOLD    = 3'd2,
        ST_REPEAT  = 3'd3,
        ST_LOCKOUT = 3'd4
    } state_e;

    typedef enum logic {
        DIR_UP = 1'b0,
        DIR_DN = 1'b1
    } dir_e;

    // Counter command bundle: ena is active-high, sum/rest are active-low.
    typedef struct packed {
        logic ena;
        logic sum;
        logic rest;
    } step_t;

    localparam step_t STEP_IDLE = '{ena: 1'b0, sum: 1'b1, rest: 1'b1};

    function automatic step_t step_of(input dir_e dir);
        step_t s;
        case (dir)
            DIR_UP:  s = '{ena: 1'b1, sum: 1'b0, rest: 1'b1};
            DIR_DN:  s = '{ena: 1'b1, sum: 1'b1, rest: 1'b0};
            default: s = STEP_IDLE;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer plus stability-count debouncer for one active-low button.
// The pressed level only changes after the synchronized level differs from it for DB_CYCLES clocks.
module btn_debounce #(
    parameter int DB_CYCLES = 50000,
    parameter int TMR_W     = 25
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n,
    output logic pressed
);

    localparam logic [TMR_W-1:0] CNT_LAST = TMR_W'(DB_CYCLES - 1);
    localparam logic [TMR_W-1:0] CNT_ONE  = TMR_W'(1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             db_q, db_d;
    logic [TMR_W-1:0] cnt_q, cnt_d;
    logic             level_s;

    // Synchronizer and debounce next-state; any return to the accepted level restarts the count.
    always_comb begin
        sync1_d = btn_n;
        sync2_d = sync1_q;
        level_s = ~sync2_q;
        db_d    = db_q;
        cnt_d   = cnt_q;
        if (level_s != db_q) begin
            if (cnt_q == CNT_LAST) begin
                db_d  = level_s;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end else begin
            cnt_d = '0;
        end
    end

    // State registers; synchronizer resets to released.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            db_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            db_q    <= db_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pressed = db_q;

endmodule

// File: rtl/selector_step_ctrl.sv
// Up/down push-button front end for the PWM duty selector counter.
// Debounces both buttons, arbitrates them, and emits single-cycle step commands with auto-repeat.
module selector_step_ctrl #(
    parameter int DB_CYCLES     = 50000,
    parameter int REPEAT_DELAY  = 25000000,
    parameter int REPEAT_PERIOD = 5000000,
    parameter int TMR_W         = 25
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_up_n,
    input  logic btn_dn_n,
    input  logic en,
    output logic step_ena,
    output logic step_sum,
    output logic step_rest,
    output logic repeating
);

    import selector_ctrl_pkg::*;

    localparam logic [TMR_W-1:0] DELAY_LOAD  = TMR_W'(REPEAT_DELAY - 1);
    localparam logic [TMR_W-1:0] PERIOD_LOAD = TMR_W'(REPEAT_PERIOD - 1);
    localparam logic [TMR_W-1:0] TMR_ONE     = TMR_W'(1);

    logic             up_db, dn_db;
    state_e           state_q, state_d;
    dir_e             dir_q, dir_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    step_t            step_q, step_d;
    logic             rep_q, rep_d;
    logic             fire_s, held_s, other_s, tmr_zero_s;

    btn_debounce #(.DB_CYCLES(DB_CYCLES), .TMR_W(TMR_W)) u_db_up (
        .clk     (clk),
        .rst     (rst),
        .btn_n   (btn_up_n),
        .pressed (up_db)
    );

    btn_debounce #(.DB_CYCLES(DB_CYCLES), .TMR_W(TMR_W)) u_db_dn (
        .clk     (clk),
        .rst     (rst),
        .btn_n   (btn_dn_n),
        .pressed (dn_db)
    );

    // State, direction, timer and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            dir_q   <= DIR_UP;
            tmr_q   <= '0;
            step_q  <= STEP_IDLE;
            rep_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            tmr_q   <= tmr_d;
            step_q  <= step_d;
            rep_q   <= rep_d;
        end
    end

    // Next-state and timer logic; fire_s marks the cycle a step falls due.
    always_comb begin
        state_d    = state_q;
        dir_d      = dir_q;
        tmr_d      = tmr_q;
        fire_s     = 1'b0;
        tmr_zero_s = (tmr_q == '0);
        held_s     = (dir_q == DIR_UP) ? up_db : dn_db;
        other_s    = (dir_q == DIR_UP) ? dn_db : up_db;
        case (state_q)
            ST_IDLE: begin
                tmr_d = '0;
                if (up_db && dn_db) begin
                    state_d = ST_LOCKOUT;
                end else if (up_db) begin
                    dir_d   = DIR_UP;
                    state_d = ST_FIRST;
                end else if (dn_db) begin
                    dir_d   = DIR_DN;
                    state_d = ST_FIRST;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FIRST: begin
                fire_s  = 1'b1;
                tmr_d   = DELAY_LOAD;
                state_d = ST_HOLD;
            end
            ST_HOLD, ST_REPEAT: begin
                if (!held_s) begin
                    tmr_d   = '0;
                    state_d = ST_IDLE;
                end else if (other_s) begin
                    tmr_d   = '0;
                    state_d = ST_LOCKOUT;
                end else if (tmr_zero_s) begin
                    fire_s  = 1'b1;
                    tmr_d   = PERIOD_LOAD;
                    state_d = ST_REPEAT;
                end else begin
                    tmr_d = tmr_q - TMR_ONE;
                end
            end
            ST_LOCKOUT: begin
                tmr_d = '0;
                if (!up_db && !dn_db) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_LOCKOUT;
                end
            end
            default: begin
                tmr_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode; a due step is dropped while en is low but the FSM keeps going.
    always_comb begin
        if (fire_s && en) begin
            step_d = step_of(dir_q);
        end else begin
            step_d = STEP_IDLE;
        end
        rep_d = (state_d == ST_REPEAT);
    end

    assign step_ena  = step_q.ena;
    assign step_sum  = step_q.sum;
    assign step_rest = step_q.rest;
    assign repeating = rep_q;

endmodule

// File: tb/tb_selector_step_ctrl.sv
// Self-checking bench for selector_step_ctrl with DB_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8.
// Expected steps are queued from a timing model at press time and matched as the DUT strobes.
module tb_selector_step_ctrl;

    localparam int DB = 4;
    localparam int RD = 20;
    localparam int RP = 8;
    localparam int TW = 8;

    logic clk = 1'b0;
    logic rst, btn_up_n, btn_dn_n, en;
    logic step_ena, step_sum, step_rest, repeating;

    always #5 clk = ~clk;

    selector_step_ctrl #(
        .DB_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .TMR_W(TW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_up_n  (btn_up_n),
        .btn_dn_n  (btn_dn_n),
        .en        (en),
        .step_ena  (step_ena),
        .step_sum  (step_sum),
        .step_rest (step_rest),
        .repeating (repeating)
    );

    typedef struct {
        int cyc;
        bit up;
        bit rep;
    } exp_t;

    typedef struct {
        bit up;
        int hold;
        int en_delay;
        int n_steps;
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   steps_seen = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Raw low first sampled at edge k; steps at k+DB+3, then +RD, then every +RP,
    // as long as the step edge is no later than the debounced release (k+hold+DB+1).
    task automatic push_grid(input int k, input bit up, input int hold, input int en_delay);
        int off;
        int idx;
        off = DB + 3;
        idx = 0;
        while (off <= hold + DB + 1) begin
            if (en_delay <= off) sb.push_back('{k + off, up, (idx > 0)});
            off += (idx == 0) ? RD : RP;
            idx++;
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                n_cmp++;
                n_bad++;
                $display("FAIL missed_step: no step seen, want step at cycle %0d", sb[0].cyc);
                void'(sb.pop_front());
            end
            if (step_ena) begin
                steps_seen++;
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_step: step_ena=1 at cycle %0d, want no step", cyc);
                end else begin
                    mon_e = sb.pop_front();
                    check("step_cycle", cyc, mon_e.cyc);
                    check("step_sum", step_sum, !mon_e.up);
                    check("step_rest", step_rest, mon_e.up);
                    check("repeating_at_step", repeating, mon_e.rep);
                end
            end else begin
                check("idle_sum_rest", {step_sum, step_rest}, 2'b11);
            end
        end
    end

    task automatic press(input bit up, input int hold, input int en_delay);
        int k;
        @(negedge clk);
        k  = cyc + 1;
        en = (en_delay == 0);
        push_grid(k, up, hold, en_delay);
        if (up) btn_up_n = 1'b0;
        else    btn_dn_n = 1'b0;
        for (int i = 1; i <= hold; i++) begin
            @(negedge clk);
            if (i == en_delay) en = 1'b1;
        end
        btn_up_n = 1'b1;
        btn_dn_n = 1'b1;
        en       = 1'b1;
        repeat (DB + 10) @(negedge clk);
        check("queue_drained", sb.size(), 0);
        check("repeating_after_release", repeating, 0);
    endtask

    vec_t vt[7];
    int   s0;
    int   k;

    initial begin
        vt[0] = '{1'b1, 10, 0, 1};
        vt[1] = '{1'b0, 10, 0, 1};
        vt[2] = '{1'b1, 60, 0, 6};
        vt[3] = '{1'b0, 30, 0, 3};
        vt[4] = '{1'b1, 22, 0, 2};
        vt[5] = '{1'b1, 21, 0, 1};
        vt[6] = '{1'b1, 60, 40, 3};

        rst = 1'b1; btn_up_n = 1'b1; btn_dn_n = 1'b1; en = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_step_ena", step_ena, 0);
        check("rst_step_sum", step_sum, 1);
        check("rst_step_rest", step_rest, 1);
        check("rst_repeating", repeating, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            s0 = steps_seen;
            press(vt[i].up, vt[i].hold, vt[i].en_delay);
            check("vector_step_count", steps_seen - s0, vt[i].n_steps);
        end

        // Bouncing down button: three 2-clock pulses, then a clean press.
        s0 = steps_seen;
        @(negedge clk);
        for (int b = 0; b < 3; b++) begin
            btn_dn_n = 1'b0;
            repeat (2) @(negedge clk);
            btn_dn_n = 1'b1;
            repeat (2) @(negedge clk);
        end
        btn_dn_n = 1'b0;
        k = cyc + 1;
        push_grid(k, 1'b0, 10, 0);
        repeat (10) @(negedge clk);
        btn_dn_n = 1'b1;
        repeat (DB + 10) @(negedge clk);
        check("bounce_drained", sb.size(), 0);
        check("bounce_step_count", steps_seen - s0, 1);

        // Up held, then down joins: lockout until both are released.
        s0 = steps_seen;
        @(negedge clk);
        k = cyc + 1;
        btn_up_n = 1'b0;
        sb.push_back('{k + DB + 3, 1'b1, 1'b0});
        repeat (10) @(negedge clk);
        btn_dn_n = 1'b0;
        repeat (20) @(negedge clk);
        btn_up_n = 1'b1;
        repeat (20) @(negedge clk);
        check("lockout_step_count", steps_seen - s0, 1);
        check("lockout_repeating", repeating, 0);
        btn_dn_n = 1'b1;
        repeat (15) @(negedge clk);
        check("lockout_drained", sb.size(), 0);
        s0 = steps_seen;
        press(1'b1, 10, 0);
        check("after_lockout_step_count", steps_seen - s0, 1);

        // Both buttons pressed in the same cycle: no step at all.
        s0 = steps_seen;
        @(negedge clk);
        btn_up_n = 1'b0;
        btn_dn_n = 1'b0;
        repeat (15) @(negedge clk);
        btn_up_n = 1'b1;
        btn_dn_n = 1'b1;
        repeat (15) @(negedge clk);
        check("simultaneous_step_count", steps_seen - s0, 0);

        // Reset in the middle of auto-repeat while up stays held.
        @(negedge clk);
        k = cyc + 1;
        btn_up_n = 1'b0;
        sb.push_back('{k + DB + 3, 1'b1, 1'b0});
        sb.push_back('{k + DB + 3 + RD, 1'b1, 1'b1});
        repeat (30) @(negedge clk);
        check("repeating_before_rst", repeating, 1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_step_ena", step_ena, 0);
        check("async_rst_sum_rest", {step_sum, step_rest}, 2'b11);
        check("async_rst_repeating", repeating, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        k = cyc + 1;
        push_grid(k, 1'b1, 30, 0);
        repeat (30) @(negedge clk);
        btn_up_n = 1'b1;
        repeat (DB + 10) @(negedge clk);
        check("post_rst_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
